// File: rtl/receiver_pkg.sv
// -----------------------------------------------------------------------------
// receiver_pkg
//   Constants and types shared by the serial receiver and the serial
//   transmitter. Both ends of the link import the same defaults, so the
//   frame width and the bit-index width always agree.
//
//   DEFAULT_WIDTH : data word width in bits.
//   DEFAULT_IND   : bit-index counter width (2**DEFAULT_IND >= DEFAULT_WIDTH).
//   state_t       : receiver FSM states on a 1-bit state register.
// -----------------------------------------------------------------------------
package receiver_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_IND   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : receiver_pkg

// File: rtl/receiver_if.sv
// -----------------------------------------------------------------------------
// receiver_if
//   Bundle of the serial link inputs and the consumer-side outputs of the
//   receiver.
//
//   RxStart  : frame-start strobe. Bit 0 arrives on RxD in the following cycle.
//   RxD      : serial data, LSB first, one bit per clock.
//   RxLast   : end-of-frame strobe, high with bit WIDTH-1.
//   RxAck    : consumer acknowledge, clears RxValid.
//   DataOut  : last correctly framed word.
//   RxValid  : DataOut holds an unacknowledged word.
//   RxBusy   : a frame is being shifted in.
//   FrameErr : one-cycle pulse when a frame is aborted.
//   Overrun  : sticky, an unacknowledged word was overwritten.
//
//   Modports:
//     slave  : the receiver itself.
//     master : the link driver plus consumer (bench or surrounding logic).
// -----------------------------------------------------------------------------
interface receiver_if #(
  parameter int WIDTH = receiver_pkg::DEFAULT_WIDTH
);

  logic             RxStart;
  logic             RxD;
  logic             RxLast;
  logic             RxAck;
  logic [WIDTH-1:0] DataOut;
  logic             RxValid;
  logic             RxBusy;
  logic             FrameErr;
  logic             Overrun;

  modport slave (
    input  RxStart,
    input  RxD,
    input  RxLast,
    input  RxAck,
    output DataOut,
    output RxValid,
    output RxBusy,
    output FrameErr,
    output Overrun
  );

  modport master (
    output RxStart,
    output RxD,
    output RxLast,
    output RxAck,
    input  DataOut,
    input  RxValid,
    input  RxBusy,
    input  FrameErr,
    input  Overrun
  );

endinterface : receiver_if

// File: rtl/receiver.sv
// -----------------------------------------------------------------------------
// receiver
//   Serial-to-parallel receiver terminating the bit-serial link of the serial
//   transmitter. A frame is one RxStart strobe followed by WIDTH data bits,
//   LSB first, with RxLast on the final bit. A correctly framed word is
//   loaded into DataOut and offered to the consumer with RxValid/RxAck.
//   A frame whose RxLast is missing, early, or interrupted by a new RxStart
//   is dropped with a one-cycle FrameErr pulse.
//
//   Ports:
//     clk   : system clock, rising edge.
//     reset : asynchronous, active-high reset.
//     bus   : receiver_if.slave (link inputs, consumer handshake, status).
//
//   Every output comes straight from a flop; there is no combinational path
//   from any input to any output.
// -----------------------------------------------------------------------------
module receiver
  import receiver_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IND   = DEFAULT_IND
) (
  input  logic      clk,
  input  logic      reset,
  receiver_if.slave bus
);

  localparam logic [IND-1:0] LAST_INDEX = IND'(WIDTH - 1);

  state_t           state,     next_state;
  logic [IND-1:0]   index,     next_index;
  logic [WIDTH-1:0] shift,     next_shift;
  logic [WIDTH-1:0] data,      next_data;
  logic             valid,     next_valid;
  logic             frame_err, next_frame_err;
  logic             overrun,   next_overrun;

  logic             last_bit;
  logic             ack_accepted;

  assign last_bit     = (index == LAST_INDEX);
  // An acknowledge only means something while a word is on offer.
  assign ack_accepted = bus.RxAck && valid;

  // ---------------------------------------------------------------------------
  // Next-state and datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    next_state     = state;
    next_index     = index;
    next_shift     = shift;
    next_data      = data;
    next_valid     = valid;
    next_frame_err = 1'b0;
    next_overrun   = overrun;

    // The handshake runs independently of the frame FSM; a completion below
    // may override next_valid again in the same cycle.
    if (ack_accepted) begin
      next_valid   = 1'b0;
      next_overrun = 1'b0;
    end

    unique case (state)
      IDLE: begin
        // RxD and RxLast carry nothing meaningful between frames.
        next_index = '0;
        if (bus.RxStart) begin
          next_state = SHIFT;
        end
      end

      SHIFT: begin
        next_shift[index] = bus.RxD;
        next_index        = index + 1'b1;

        // RxLast must coincide exactly with the final bit: a mismatch in
        // either direction (missing or early) aborts, as does a restart.
        if (bus.RxStart || (bus.RxLast != last_bit)) begin
          next_frame_err = 1'b1;
          next_state     = IDLE;
        end else if (last_bit) begin
          // The final bit is taken straight from RxD so the word is
          // visible one cycle after the last bit, not two.
          next_data  = {bus.RxD, shift[WIDTH-2:0]};
          next_valid = 1'b1;
          // Overwriting an unacknowledged word is an overrun, unless the
          // consumer acknowledges the old word in this very cycle.
          if (valid && !bus.RxAck) begin
            next_overrun = 1'b1;
          end
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= next_state;
      index     <= next_index;
      shift     <= next_shift;
      data      <= next_data;
      valid     <= next_valid;
      frame_err <= next_frame_err;
      overrun   <= next_overrun;
    end
  end

  assign bus.DataOut  = data;
  assign bus.RxValid  = valid;
  assign bus.RxBusy   = (state == SHIFT);
  assign bus.FrameErr = frame_err;
  assign bus.Overrun  = overrun;

endmodule : receiver

// File: tb/tb_receiver.sv
// -----------------------------------------------------------------------------
// tb_receiver
//   Directed self-checking bench for the serial receiver. Inputs change 1 ns
//   after a rising edge and outputs are sampled at the same point, so every
//   sample sees the state written by the preceding edge.
// -----------------------------------------------------------------------------
module tb_receiver;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int errors = 0;
  int checks = 0;

  receiver_if #(.WIDTH(8)) bus ();

  receiver #(.WIDTH(8), .IND(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame: RxStart for a cycle, then up to 8 bits of word.
  // last_pos : bit index carrying RxLast (-1 for none).
  // start_pos: bit index carrying a stray RxStart (-1 for none).
  // ack_last : RxAck high together with bit 7.
  // Stops driving right after an aborting bit.
  task automatic run_frame(input logic [7:0] word, input int last_pos,
                           input int start_pos, input bit ack_last,
                           output bit err_seen, output bit early_valid);
    err_seen    = 1'b0;
    early_valid = 1'b0;
    bus.RxStart = 1'b1;
    bus.RxD     = 1'b0;
    bus.RxLast  = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      bus.RxStart = (i == start_pos);
      bus.RxD     = word[i];
      bus.RxLast  = (i == last_pos);
      bus.RxAck   = ack_last && (i == 7);
      step();
      if (bus.FrameErr === 1'b1) err_seen = 1'b1;
      if (i < 7 && bus.RxValid === 1'b1) early_valid = 1'b1;
      if (i == start_pos || (i == last_pos && i != 7)) break;
    end
    bus.RxStart = 1'b0;
    bus.RxD     = 1'b0;
    bus.RxLast  = 1'b0;
    bus.RxAck   = 1'b0;
  endtask

  task automatic acknowledge();
    bus.RxAck = 1'b1;
    step();
    bus.RxAck = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.DataOut !== 8'h00) begin errors++; $display("FAIL reset_dataout: got %h expected 00", bus.DataOut); end
    checks++; if (bus.RxValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.RxValid); end
    checks++; if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.RxBusy); end
    checks++; if (bus.FrameErr !== 1'b0) begin errors++; $display("FAIL reset_frameerr: got %b expected 0", bus.FrameErr); end
    checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.Overrun); end
    step();
    step();
    #3 reset = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    bit e, ev;
    run_frame(8'hA5, 7, -1, 1'b0, e, ev);
    checks++; if (bus.DataOut !== 8'hA5) begin errors++; $display("FAIL nominal_data: got %h expected a5", bus.DataOut); end
    checks++; if (bus.RxValid !== 1'b1) begin errors++; $display("FAIL nominal_valid: got %b expected 1", bus.RxValid); end
    checks++; if (ev !== 1'b0) begin errors++; $display("FAIL nominal_latency: valid early got %b expected 0", ev); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL nominal_frameerr: got %b expected 0", e); end
    checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL nominal_overrun: got %b expected 0", bus.Overrun); end
    checks++; if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL nominal_busy_end: got %b expected 0", bus.RxBusy); end
    acknowledge();
    checks++; if (bus.RxValid !== 1'b0) begin errors++; $display("FAIL nominal_ack: valid got %b expected 0", bus.RxValid); end
    checks++; if (bus.DataOut !== 8'hA5) begin errors++; $display("FAIL nominal_hold: got %h expected a5", bus.DataOut); end
    // Acknowledge with nothing on offer changes nothing.
    acknowledge();
    checks++; if (bus.RxValid !== 1'b0 || bus.Overrun !== 1'b0) begin errors++; $display("FAIL ack_idle: valid=%b overrun=%b expected 0 0", bus.RxValid, bus.Overrun); end
  endtask

  task automatic test_missing_last();
    bit e, ev;
    run_frame(8'h5A, -1, -1, 1'b0, e, ev);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL missing_last_err: got %b expected 1", e); end
    checks++; if (bus.DataOut !== 8'hA5) begin errors++; $display("FAIL missing_last_data: got %h expected a5", bus.DataOut); end
    checks++; if (bus.RxValid !== 1'b0) begin errors++; $display("FAIL missing_last_valid: got %b expected 0", bus.RxValid); end
    checks++; if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL missing_last_idle: busy got %b expected 0", bus.RxBusy); end
    step();
    checks++; if (bus.FrameErr !== 1'b0) begin errors++; $display("FAIL missing_last_pulse: got %b expected 0", bus.FrameErr); end
  endtask

  task automatic test_early_last();
    bit e, ev;
    run_frame(8'hFF, 3, -1, 1'b0, e, ev);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL early_last_err: got %b expected 1", e); end
    checks++; if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL early_last_idle: busy got %b expected 0", bus.RxBusy); end
    step();
    run_frame(8'h3C, 7, -1, 1'b0, e, ev);
    checks++; if (bus.DataOut !== 8'h3C || bus.RxValid !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL early_last_recover: data=%h valid=%b err=%b expected 3c 1 0", bus.DataOut, bus.RxValid, e); end
    acknowledge();
  endtask

  task automatic test_restart();
    bit e, ev;
    run_frame(8'h00, -1, 4, 1'b0, e, ev);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL restart_err: got %b expected 1", e); end
    checks++; if (bus.RxBusy !== 1'b0) begin errors++; $display("FAIL restart_no_new_frame: busy got %b expected 0", bus.RxBusy); end
    step();
    run_frame(8'hC3, 7, -1, 1'b0, e, ev);
    checks++; if (bus.DataOut !== 8'hC3 || bus.RxValid !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL restart_recover: data=%h valid=%b err=%b expected c3 1 0", bus.DataOut, bus.RxValid, e); end
    acknowledge();
  endtask

  task automatic test_overrun();
    bit e, ev;
    run_frame(8'h11, 7, -1, 1'b0, e, ev);
    step();
    run_frame(8'h22, 7, -1, 1'b0, e, ev);
    checks++; if (bus.DataOut !== 8'h22) begin errors++; $display("FAIL overrun_data: got %h expected 22", bus.DataOut); end
    checks++; if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", bus.Overrun); end
    checks++; if (bus.RxValid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", bus.RxValid); end
    step();
    checks++; if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", bus.Overrun); end
    acknowledge();
    checks++; if (bus.RxValid !== 1'b0 || bus.Overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: valid=%b overrun=%b expected 0 0", bus.RxValid, bus.Overrun); end
    // Same again, with the acknowledge coinciding with the 8'h22 completion.
    run_frame(8'h11, 7, -1, 1'b0, e, ev);
    step();
    run_frame(8'h22, 7, -1, 1'b1, e, ev);
    checks++; if (bus.DataOut !== 8'h22 || bus.RxValid !== 1'b1) begin errors++; $display("FAIL coincident_ack_data: data=%h valid=%b expected 22 1", bus.DataOut, bus.RxValid); end
    checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL coincident_ack_overrun: got %b expected 0", bus.Overrun); end
    acknowledge();
  endtask

  task automatic test_async_reset();
    bit e, ev;
    // Leave a valid, overrun word behind so the reset has something to clear.
    run_frame(8'h11, 7, -1, 1'b0, e, ev);
    step();
    run_frame(8'h22, 7, -1, 1'b0, e, ev);
    bus.RxStart = 1'b1;
    step();
    bus.RxStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.RxD = 1'b1;
      step();
    end
    checks++; if (bus.RxBusy !== 1'b1) begin errors++; $display("FAIL areset_busy_before: got %b expected 1", bus.RxBusy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.DataOut !== 8'h00 || bus.RxValid !== 1'b0 || bus.RxBusy !== 1'b0 || bus.FrameErr !== 1'b0 || bus.Overrun !== 1'b0) begin
      errors++; $display("FAIL areset_outputs: data=%h valid=%b busy=%b err=%b overrun=%b expected all 0", bus.DataOut, bus.RxValid, bus.RxBusy, bus.FrameErr, bus.Overrun);
    end
    step();
    checks++; if (bus.FrameErr !== 1'b0) begin errors++; $display("FAIL areset_no_err: got %b expected 0", bus.FrameErr); end
    bus.RxD = 1'b0;
    #3 reset = 1'b0;
    step();
    checks++; if (bus.FrameErr !== 1'b0 || bus.RxBusy !== 1'b0) begin errors++; $display("FAIL areset_after: err=%b busy=%b expected 0 0", bus.FrameErr, bus.RxBusy); end
    run_frame(8'hF0, 7, -1, 1'b0, e, ev);
    checks++; if (bus.DataOut !== 8'hF0 || bus.RxValid !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL areset_frame: data=%h valid=%b err=%b expected f0 1 0", bus.DataOut, bus.RxValid, e); end
    acknowledge();
  endtask

  // Transmitter-style stream: next RxStart in the cycle right after the last
  // bit, with the consumer acknowledging in that same cycle.
  task automatic test_back_to_back();
    bit e, ev;
    int bad = 0;
    for (int w = 0; w < 256; w++) begin
      run_frame(w[7:0], 7, -1, 1'b0, e, ev);
      checks++;
      if (bus.DataOut !== w[7:0] || bus.RxValid !== 1'b1 || e !== 1'b0 || bus.Overrun !== 1'b0) begin
        errors++;
        if (bad < 5) $display("FAIL b2b_word_%0d: data=%h valid=%b err=%b overrun=%b expected %h 1 0 0", w, bus.DataOut, bus.RxValid, e, bus.Overrun, w[7:0]);
        bad++;
      end
      bus.RxAck = 1'b1;
    end
    step();
    bus.RxAck = 1'b0;
    checks++; if (bus.RxValid !== 1'b0 || bus.Overrun !== 1'b0 || bus.FrameErr !== 1'b0) begin errors++; $display("FAIL b2b_end: valid=%b overrun=%b err=%b expected 0 0 0", bus.RxValid, bus.Overrun, bus.FrameErr); end
  endtask

  initial begin
    bus.RxStart = 1'b0;
    bus.RxD     = 1'b0;
    bus.RxLast  = 1'b0;
    bus.RxAck   = 1'b0;
    test_reset();
    test_nominal();
    test_missing_last();
    test_early_last();
    test_restart();
    test_overrun();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_receiver

// File: doc/receiver.md
Name: receiver

Overview:
- Serial-to-parallel receiver. Terminates the bit-serial link driven by the team's serial transmitter.
- Frame format: one start strobe (`RxStart`, wired to the transmitter's ready strobe). On the following WIDTH cycles the data bits arrive LSB first, one per clock. The last bit arrives together with a done strobe (`RxLast`).
- Reassembles the word, checks framing against `RxLast`, and presents the word to the consumer with a valid/ack handshake and an overrun flag.

Parameters:
- WIDTH, 8, data word width in bits.
- IND, 3, bit-index counter width; must satisfy 2^IND >= WIDTH.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- RxStart  input  1  frame-start strobe. Bit 0 is on RxD in the cycle after RxStart is high.
- RxD  input  1  serial data, LSB first, one bit per clk.
- RxLast  input  1  end-of-frame strobe. Must be high exactly in the cycle carrying bit WIDTH-1.
- RxAck  input  1  consumer acknowledge; clears RxValid.
- DataOut  output  WIDTH  last correctly framed word; held stable while RxValid=1.
- RxValid  output  1  DataOut holds an unacknowledged word.
- RxBusy  output  1  frame in progress (state SHIFT).
- FrameErr  output  1  one-cycle pulse: frame aborted.
- Overrun  output  1  sticky: a word was overwritten before it was acknowledged.

Behaviour:
- Reset (async, reset=1): state=IDLE, index=0, shift register=0. All outputs are 0: DataOut, RxValid, RxBusy, FrameErr, Overrun. Reset asserted mid-frame discards the partial word; no FrameErr is raised.
- State IDLE:
  - index<=0, RxBusy=0.
  - If RxStart=1 at the clock edge, go to SHIFT. RxD and RxLast are ignored in IDLE.
- State SHIFT:
  - Each edge: shift[index]<=RxD, index<=index+1.
  - Normal end: if index==WIDTH-1 and RxLast=1, the frame completes. The completed word is {RxD, shift[WIDTH-2:0]}. It is written to DataOut on that same edge. RxValid<=1. Next state is IDLE.
  - Abort, missing done strobe: index==WIDTH-1 and RxLast=0. FrameErr pulses for one cycle; DataOut and RxValid are unchanged; go to IDLE.
  - Abort, early done strobe: RxLast=1 with index<WIDTH-1. Same action as above.
  - Abort, restart mid-frame: RxStart=1 in SHIFT. FrameErr pulses; go to IDLE. This RxStart does not start a new frame.
- Latency: DataOut/RxValid are visible the cycle after the last bit is on RxD. That is WIDTH+1 cycles after RxStart is visible.
- Back-to-back frames: at least one IDLE cycle falls between the last bit and the next RxStart sample. This matches the transmitter's minimum gap; no bit is lost.
- Handshake:
  - RxAck=1 while RxValid=1 clears RxValid on the next edge. RxAck while RxValid=0 is ignored.
  - Completion and RxAck in the same cycle: the new word loads, RxValid stays 1, Overrun is not set.
  - Completion while RxValid=1 and RxAck=0: DataOut is overwritten with the new word and Overrun<=1.
- Overrun remains set until an RxAck is accepted or reset. An RxAck in the same cycle as a new overrun completion leaves Overrun=0.
- index is IND bits wide and never wraps in normal operation, because it returns to 0 in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - state localparams: IDLE=0, SHIFT=1, on a 1-bit state register.
  - default WIDTH/IND constants, shared with the transmitter so both ends agree.
- No sub-module required. This is a single FSM plus a shift register and output register. An optional loopback top, `serial_loopback`, pairs transmitter and receiver for test only.

Test Plan:
- Nominal frame: RxStart 1 cycle, then RxD=1,0,1,0,0,1,0,1 with RxLast on the 8th bit -> DataOut=8'hA5, RxValid=1 one cycle later, FrameErr=0, Overrun=0.
- Missing RxLast: same frame with RxLast held 0 -> FrameErr pulse in the cycle after bit 7; DataOut keeps its prior value; RxValid unchanged; state returns to IDLE.
- Early RxLast or mid-frame RxStart: RxLast=1 on bit 3 (or RxStart=1 on bit 4) -> FrameErr pulse; the next clean frame 8'h3C is received correctly.
- Overrun: frames 8'h11 then 8'h22 with no RxAck -> DataOut=8'h22, Overrun=1. A later RxAck clears RxValid and Overrun. Repeat with RxAck coincident with completion of 8'h22 -> Overrun stays 0.
- Async reset: assert reset after bit 4 of a frame, deassert, send 8'hF0 -> all outputs 0 during reset and no FrameErr; DataOut=8'hF0 after the frame.
- Loopback: transmitter TxD/TxReady/TxDone wired to RxD/RxStart/RxLast, 256 back-to-back words 0..255 with an acknowledging consumer -> every word matches, FrameErr and Overrun never assert.
